// File: rtl/dequ_pkg.sv
// Shared constants, FSM state encoding and block-entry type for the dequantizer stream feeder.
package dequ_pkg;

  localparam int DEQU_L2_WIDTH  = 512;
  localparam int DEQU_SWIDTH    = 5;
  localparam int DEQU_OFF_WIDTH = 9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EMIT  = 2'd1,
    S_STALL = 2'd2
  } dequ_state_e;

  typedef struct packed {
    logic [DEQU_L2_WIDTH-1:0] data;
    logic [DEQU_SWIDTH-1:0]   width;
    logic                     valid;
  } blk_entry_t;

endpackage

// File: rtl/dequ_blk_fifo2.sv
// Two-entry block buffer: head is the active block being unpacked, tail is the pending one.
module dequ_blk_fifo2
  import dequ_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push_valid,
  output logic       o_push_ready,
  input  blk_entry_t i_push_ent,
  input  logic       i_pop,
  output blk_entry_t o_head,
  output logic       o_pending
);

  blk_entry_t r_head;
  blk_entry_t r_tail;
  logic       w_push;

  assign o_push_ready = !r_tail.valid;
  assign w_push       = i_push_valid && o_push_ready;
  assign o_head       = r_head;
  assign o_pending    = r_tail.valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (i_pop) begin
      // A push can coincide with a pop only when the tail is empty.
      if (r_tail.valid) begin
        r_head <= r_tail;
        r_tail <= '0;
      end else if (w_push) begin
        r_head <= i_push_ent;
      end else begin
        r_head <= '0;
      end
    end else if (w_push) begin
      if (!r_head.valid) r_head <= i_push_ent;
      else               r_tail <= i_push_ent;
    end
  end

endmodule

// File: rtl/dequ_stream_feeder.sv
// Feeds word descriptors (block, width, bit offset, last) of compressed L2 blocks to a dequantizer.
// Define DEQU_FEEDER_STATS_EN to add the WordCnt/StallCnt statistics outputs.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready,
// and a presented descriptor is held unchanged until it transfers.
module dequ_stream_feeder
  import dequ_pkg::*;
#(
  parameter int L2_WIDTH = DEQU_L2_WIDTH,
  parameter int SWIDTH   = DEQU_SWIDTH
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [L2_WIDTH-1:0]       BlkData,
  input  logic [SWIDTH-1:0]         BlkWidth,
  input  logic                      BlkValid,
  output logic                      BlkReady,
  output logic [L2_WIDTH-1:0]       InpuStr,
  output logic [SWIDTH-1:0]         NumShift,
  output logic [DEQU_OFF_WIDTH-1:0] AccNumShift,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic                      OutLast,
  output logic                      CfgErr,
`ifdef DEQU_FEEDER_STATS_EN
  output logic [31:0]               WordCnt,
  output logic [31:0]               StallCnt,
`endif
  output logic [1:0]                o_dbg_state
);

  dequ_state_e               r_state;
  dequ_state_e               w_state_next;
  logic [DEQU_OFF_WIDTH-1:0] r_acc;
  logic                      r_cfg_err;

  blk_entry_t                w_push_ent;
  blk_entry_t                w_head;
  logic                      w_pending;
  logic                      w_push_valid;
  logic                      w_blk_fire;
  logic                      w_fire;
  logic                      w_last;
  logic                      w_pop;
  logic                      w_active_next;
  logic [DEQU_OFF_WIDTH:0]   w_acc_sum;
  logic [DEQU_OFF_WIDTH+1:0] w_acc_end;

  // Zero-width blocks are accepted but never enter the buffer.
  assign w_push_valid = BlkValid && (BlkWidth != '0);
  assign w_blk_fire   = BlkValid && BlkReady;
  assign w_push_ent   = '{data: BlkData, width: BlkWidth, valid: 1'b1};

  dequ_blk_fifo2 u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push_valid (w_push_valid),
    .o_push_ready (BlkReady),
    .i_push_ent   (w_push_ent),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_pending    (w_pending)
  );

  // Offset of the following word, and the end of the word after it; if that overruns the block,
  // the current word is the last one that fits.
  assign w_acc_sum = {1'b0, r_acc} + {{(DEQU_OFF_WIDTH+1-SWIDTH){1'b0}}, w_head.width};
  assign w_acc_end = {1'b0, w_acc_sum} + {{(DEQU_OFF_WIDTH+2-SWIDTH){1'b0}}, w_head.width};

  assign OutValid    = (r_state != S_IDLE);
  assign w_last      = OutValid && (w_acc_end > (DEQU_OFF_WIDTH+2)'(L2_WIDTH));
  assign w_fire      = OutValid && OutReady;
  assign w_pop       = w_fire && w_last;
  assign OutLast     = w_last;
  assign InpuStr     = w_head.data;
  assign NumShift    = w_head.width;
  assign AccNumShift = r_acc;
  assign CfgErr      = r_cfg_err;
  assign o_dbg_state = r_state;

  assign w_active_next = w_pop ? (w_pending || (w_push_valid && BlkReady))
                               : (w_head.valid || (w_push_valid && BlkReady));

  always_comb begin
    w_state_next = S_IDLE;
    if (w_active_next) begin
      if (OutValid && !OutReady) w_state_next = S_STALL;
      else                       w_state_next = S_EMIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cfg_err <= w_blk_fire && (BlkWidth == '0);
      if (w_fire) begin
        if (w_last) r_acc <= '0;
        else        r_acc <= w_acc_sum[DEQU_OFF_WIDTH-1:0];
      end
    end
  end

`ifdef DEQU_FEEDER_STATS_EN
  logic [31:0] r_word_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_fire)               r_word_cnt  <= r_word_cnt + 32'd1;
      if (OutValid && !OutReady) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign WordCnt  = r_word_cnt;
  assign StallCnt = r_stall_cnt;
`endif

endmodule

// File: doc/dequ_stream_feeder.md
DEQU_STREAM_FEEDER -- requirements
Module: dequ_stream_feeder

Interface
REQ-001 The block SHALL expose parameter L2_WIDTH, default 512, width of one compressed L2 block in bits.
REQ-002 The block SHALL expose parameter SWIDTH, default 5, width of the per-word code-width field.
REQ-003 The block SHALL expose port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL expose port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL expose port BlkData, input, L2_WIDTH, the compressed L2 block.
REQ-006 The block SHALL expose port BlkWidth, input, SWIDTH, the code width w in bits for every word of that block.
REQ-007 The block SHALL expose port BlkValid, input, 1, upstream block-offer flag.
REQ-008 The block SHALL expose port BlkReady, output, 1, block-accept flag.
REQ-009 The block SHALL expose port InpuStr, output, L2_WIDTH, the block currently being unpacked.
REQ-010 The block SHALL expose port NumShift, output, SWIDTH, code width of the current word.
REQ-011 The block SHALL expose port AccNumShift, output, 9, bit offset of the current word inside InpuStr.
REQ-012 The block SHALL expose port OutValid, output, 1, a word descriptor is presented.
REQ-013 The block SHALL expose port OutReady, input, 1, the downstream dequantizer accepts the descriptor.
REQ-014 The block SHALL expose port OutLast, output, 1, the presented word is the final word of its block.
REQ-015 The block SHALL expose port CfgErr, output, 1, one-cycle pulse on an illegal block.

Function
REQ-016 A block transfer SHALL occur on a cycle where BlkValid && BlkReady; a word transfer SHALL occur on a cycle where OutValid && OutReady.
REQ-017 The block SHALL hold two block entries: one active and one pending; BlkReady SHALL be 1 whenever the pending entry is empty.
REQ-018 The FSM SHALL have states IDLE (no active entry), EMIT (active entry draining) and STALL (OutValid=1, OutReady=0).
REQ-019 A block accepted in cycle N while IDLE SHALL produce OutValid=1 with AccNumShift=0 in cycle N+1.
REQ-020 After each word transfer, AccNumShift SHALL advance by w, computed in 10 bits.
REQ-021 OutLast SHALL be 1 when AccNumShift + 2w > L2_WIDTH, which gives floor(L2_WIDTH/w) words per block.
REQ-022 On transfer of the OutLast word, the pending entry SHALL become active in the same edge, and the next cycle SHALL present its word 0 with no bubble. If no entry is pending, the FSM SHALL return to IDLE.
REQ-023 If a new block is accepted in the same cycle the last word of the active block transfers and no entry is pending, the new block SHALL become active directly.
REQ-024 While OutValid=1 and OutReady=0, InpuStr, NumShift, AccNumShift and OutLast SHALL be held stable.
REQ-025 A block with BlkWidth=0 SHALL be accepted and discarded, SHALL pulse CfgErr for one cycle, and SHALL not emit any word.
REQ-026 NumShift SHALL equal the BlkWidth latched with the active block; changes on BlkWidth SHALL take effect only at block accept.

Reset
REQ-027 While rst_n=0, the block SHALL force OutValid=0, OutLast=0, CfgErr=0, AccNumShift=0, NumShift=0, InpuStr=0 and FSM=IDLE, and SHALL invalidate both entries.
REQ-028 BlkReady SHALL be 1 from the first edge after rst_n deasserts.
REQ-029 A reset asserted mid-block SHALL discard all buffered data without emitting further words.

Configuration
REQ-030 With DEQU_FEEDER_STATS_EN defined, the block SHALL add output WordCnt[31:0], counting word transfers, and output StallCnt[31:0], counting STALL cycles. Both counters SHALL wrap at 2^32 and reset to 0.
REQ-031 With DEQU_FEEDER_STATS_EN undefined, these ports and counters SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-032 Package dequ_pkg SHALL hold L2_WIDTH, SWIDTH, the offset width (9), the FSM state enum, and a typedef blk_entry_t {data, width, valid}.
REQ-033 The two-entry block buffer SHALL be a sub-module, dequ_blk_fifo2, with a valid/ready push and a pop; the FSM and offset counter SHALL live in the top module.

Verification
REQ-034 Reset: hold rst_n=0 with BlkValid=1 -> OutValid=0, AccNumShift=0; one cycle after release, BlkReady=1.
REQ-035 w=16, single block, OutReady=1 -> 32 words with AccNumShift 0,16,...,496; OutLast only on 496; then IDLE.
REQ-036 w=7 -> 73 words; last AccNumShift=504 with OutLast=1; no word at 511.
REQ-037 Two back-to-back w=16 blocks, OutReady=1 -> 64 words on 64 consecutive cycles; AccNumShift wraps 496->0 at word 33.
REQ-038 Drop OutReady for 5 cycles while AccNumShift=48 -> all outputs stable for 5 cycles; StallCnt=5 if stats are compiled in.
REQ-039 BlkWidth=0 block, then a w=8 block -> one CfgErr pulse, then 64 words from the w=8 block only.
